// File: rtl/rom_seq.sv
// rom_seq: registered lookup-table sequencer. Streams a run of constant
// table words over a valid/ready output with wrap-around addressing,
// optional looping and synchronous abort.
// Define ROM_SEQ_CSUM_EN to build the running checksum of accepted words;
// without it csum is tied to zero.
module rom_seq #(
    parameter int N = 3,
    parameter int O = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] base,
    input  logic [N:0]   len,
    input  logic         loop,
    input  logic         stop,
    output logic [O-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [O-1:0] csum
);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t       state, state_d;
    logic [N-1:0] addr, addr_d, base_q, base_d;
    logic [N:0]   rem, rem_d, len_q, len_d;
    logic         loop_q, loop_d;
    logic [O-1:0] data_d;
    logic         valid_d, done_d;
    logic         accept, free;

    // Constant table; any address beyond the eight defined entries reads 9998.
    function automatic logic [O-1:0] rom_word(input logic [N-1:0] a);
        logic [13:0] w;
        case (32'(a))
            32'd0:   w = 14'd1;
            32'd1:   w = 14'd17;
            32'd2:   w = 14'd23;
            32'd3:   w = 14'd57;
            32'd4:   w = 14'd234;
            32'd5:   w = 14'd9;
            32'd6:   w = 14'd4878;
            32'd7:   w = 14'd9999;
            default: w = 14'd9998;
        endcase
        return O'(w);
    endfunction

    assign accept = out_valid & out_ready;
    assign free   = ~out_valid | out_ready;
    assign busy   = (state != IDLE);

    // Next-state and next-value logic for the sequencer and output register.
    always_comb begin
        state_d = state;
        addr_d  = addr;
        rem_d   = rem;
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        data_d  = out_data;
        valid_d = out_valid;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        base_d  = base;
                        len_d   = len;
                        loop_d  = loop;
                        addr_d  = base;
                        rem_d   = len;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (free) begin
                    data_d  = rom_word(addr);
                    valid_d = 1'b1;
                    addr_d  = addr + 1'b1;
                    rem_d   = rem - 1'b1;
                    if (rem == (N+1)'(1)) begin
                        if (loop_q) begin
                            addr_d = base_q;
                            rem_d  = len_q;
                        end else begin
                            state_d = LAST;
                        end
                    end
                end
            end
            LAST: begin
                if (stop) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (accept) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, run parameters and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            base_q    <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            rem       <= rem_d;
            base_q    <= base_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            done      <= done_d;
        end
    end

`ifdef ROM_SEQ_CSUM_EN
    logic [O-1:0] csum_q;
    logic         csum_clr, csum_add;

    // An abort discards the pending word, so a stop cycle never adds.
    assign csum_clr = (state == IDLE) & start;
    assign csum_add = (state != IDLE) & ~stop & accept;

    // Running modulo-2^O sum of accepted words, cleared on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (csum_clr) begin
            csum_q <= '0;
        end else if (csum_add) begin
            csum_q <= csum_q + out_data;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_rom_seq.sv
// tb_rom_seq: table-driven bench for rom_seq (N=4) plus hand-written
// sequences for loop/stop, zero-length start and mid-run reset.
module tb_rom_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base = '0;
    logic [4:0]  len = '0;
    logic        loop = 1'b0;
    logic        stop = 1'b0;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [13:0] csum;

    int passed = 0;
    int total  = 0;

    rom_seq #(.N(4), .O(14)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .loop(loop), .stop(stop), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .csum(csum)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] exp_csum(input logic [13:0] m);
`ifdef ROM_SEQ_CSUM_EN
        return 32'(m);
`else
        return 32'(m & 14'd0);
`endif
    endfunction

    typedef struct {
        logic [3:0]        base;
        logic [4:0]        len;
        logic [7:0]        rdy;
        logic              poke;
        logic [0:7][13:0]  exp;
    } vec_t;

    // Runs one non-loop start from a negedge; returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int k = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [13:0] prev = '0;
        logic [13:0] csm = '0;
        logic r;
        start = 1'b1; base = v.base; len = v.len; loop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (k < int'(v.len) && cyc < 60) begin
            if (cyc == 0) begin
                chk($sformatf("v%0d_busy_after_start", idx), busy, 1);
                chk($sformatf("v%0d_valid_latency0", idx), out_valid, 0);
            end
            if (cyc == 1) chk($sformatf("v%0d_valid_latency1", idx), out_valid, 1);
            if (stall) begin
                chk($sformatf("v%0d_hold_data", idx), out_data, prev);
                chk($sformatf("v%0d_hold_valid", idx), out_valid, 1);
            end
            chk($sformatf("v%0d_no_early_done", idx), done, 0);
            r = (cyc == 0) ? 1'b0 : v.rdy[(cyc - 1) % 8];
            out_ready = r;
            start = (v.poke && cyc == 2);
            if (start) begin base = 4'd5; len = 5'd1; end
            if (out_valid && r) begin
                chk($sformatf("v%0d_word%0d", idx, k), out_data, v.exp[k]);
                csm = csm + v.exp[k];
                k++;
            end
            stall = out_valid && !r;
            prev = out_data;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (k < int'(v.len)) chk($sformatf("v%0d_timeout_words", idx), k, v.len);
        out_ready = 1'b0;
        chk($sformatf("v%0d_done", idx), done, 1);
        chk($sformatf("v%0d_busy_low", idx), busy, 0);
        chk($sformatf("v%0d_valid_low", idx), out_valid, 0);
        chk($sformatf("v%0d_csum", idx), csum, exp_csum(csm));
        @(negedge clk);
        chk($sformatf("v%0d_done_single", idx), done, 0);
    endtask

    vec_t vecs [6];

    initial begin
        logic [13:0] lp [3];
        logic [13:0] csm;
        int k;
        int cyc;

        vecs[0] = '{base: 4'd0, len: 5'd8, rdy: 8'hFF, poke: 1'b0,
                    exp: {14'd1, 14'd17, 14'd23, 14'd57, 14'd234, 14'd9, 14'd4878, 14'd9999}};
        vecs[1] = '{base: 4'd6, len: 5'd4, rdy: 8'hFF, poke: 1'b0,
                    exp: {14'd4878, 14'd9999, 14'd9998, 14'd9998, 14'd0, 14'd0, 14'd0, 14'd0}};
        vecs[2] = '{base: 4'd15, len: 5'd2, rdy: 8'hFF, poke: 1'b0,
                    exp: {14'd9998, 14'd1, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}};
        vecs[3] = '{base: 4'd0, len: 5'd3, rdy: 8'b1110_1001, poke: 1'b0,
                    exp: {14'd1, 14'd17, 14'd23, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}};
        vecs[4] = '{base: 4'd0, len: 5'd3, rdy: 8'hFF, poke: 1'b1,
                    exp: {14'd1, 14'd17, 14'd23, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}};
        vecs[5] = '{base: 4'd14, len: 5'd3, rdy: 8'b0101_0101, poke: 1'b0,
                    exp: {14'd9998, 14'd9998, 14'd1, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_csum", csum, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Loop run of 23,57,234 for nine words, then stop while the tenth is offered
        lp[0] = 14'd23; lp[1] = 14'd57; lp[2] = 14'd234;
        csm = '0; k = 0; cyc = 0;
        out_ready = 1'b1;
        start = 1'b1; base = 4'd2; len = 5'd3; loop = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        while (k < 9 && cyc < 40) begin
            if (out_valid) begin
                chk($sformatf("loop_word%0d", k), out_data, lp[k % 3]);
                csm = csm + lp[k % 3];
                k++;
            end
            chk("loop_no_done", done, 0);
            @(negedge clk);
            cyc++;
        end
        if (k < 9) chk("loop_timeout_words", k, 9);
        chk("loop_tenth_valid", out_valid, 1);
        chk("loop_tenth_data", out_data, 23);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        out_ready = 1'b0;
        chk("stop_valid_low", out_valid, 0);
        chk("stop_busy_low", busy, 0);
        chk("stop_no_done", done, 0);
        chk("stop_csum", csum, exp_csum(csm));
        @(negedge clk);
        chk("stop_no_done_later", done, 0);
        chk("stop_csum_hold", csum, exp_csum(csm));

        // Zero-length start: done next cycle, never valid
        start = 1'b1; base = 4'd3; len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_valid", out_valid, 0);
        chk("len0_busy", busy, 0);
        @(negedge clk);
        chk("len0_done_single", done, 0);
        chk("len0_valid_later", out_valid, 0);

        // Asynchronous reset mid-run with a word pending
        start = 1'b1; base = 4'd0; len = 5'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrun_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", out_valid, 0);
        chk("midrun_rst_data", out_data, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_csum", csum, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_done", done, 0);
        run_vec('{base: 4'd5, len: 5'd1, rdy: 8'hFF, poke: 1'b0,
                  exp: {14'd9, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}}, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
